// File: rtl/rlbp_pkg.sv
// Shared types and constants for the rlbp serial code receiver.
// Signal lane indices address the packed synchronizer pipeline in the top.
package rlbp_pkg;
  localparam int CODE_W_DEF  = 12;
  localparam int SYNC_STAGES = 2;

  localparam int SIG_CLK   = 0;
  localparam int SIG_START = 1;
  localparam int SIG_DONE  = 2;
  localparam int SIG_DATA  = 3;
  localparam int NUM_SIGS  = 4;

  typedef enum logic [1:0] {IDLE, RECV, CHECK} rx_state_t;
endpackage

// File: rtl/rlbp_code_fifo.sv
// Small synchronous FIFO for received codes; head is zero while empty.
// A push into a full FIFO is accepted when a pop lands in the same cycle.
module rlbp_code_fifo #(
  parameter int DEPTH  = 4,
  parameter int CODE_W = 12
) (
  input  logic                     gclk,
  input  logic                     grst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [CODE_W-1:0]        data_i,
  output logic [CODE_W-1:0]        data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [AW:0]                   wr_q, wr_d, rd_q, rd_d;
  logic [DEPTH-1:0][CODE_W-1:0]  mem_q, mem_d;
  logic                          do_push, do_pop;

  assign level_o = wr_q - rd_q;
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (level_o == FULL_LVL);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d  = wr_q + (AW+1)'(do_push);
    rd_d  = rd_q + (AW+1)'(do_pop);
    mem_d = mem_q;
    if (do_push) mem_d[wr_q[AW-1:0]] = data_i;
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      mem_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/rlbp_code_receiver.sv
// Oversampling receiver for the rlbp serial code stream: deserializes frames,
// checks their length and queues good codes behind a valid/ready interface.
module rlbp_code_receiver
  import rlbp_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEF,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_ni,
  input  logic                      enable_i,
  input  logic                      ser_clk_i,
  input  logic                      ser_start_i,
  input  logic                      ser_data_i,
  input  logic                      ser_done_i,
  output logic [CODE_W-1:0]         code_o,
  output logic                      code_valid_o,
  input  logic                      code_ready_i,
  output logic [$clog2(DEPTH):0]    fifo_level_o,
  output logic [CNT_W-1:0]          frame_cnt_o,
  output logic                      err_short_o,
  output logic                      err_long_o,
  output logic                      overflow_o,
  input  logic                      clr_err_i
);
  localparam int BCW = $clog2(CODE_W + 2);
  localparam logic [BCW-1:0] BIT_FULL = BCW'(CODE_W);
  localparam logic [BCW-1:0] BIT_SAT  = BCW'(CODE_W + 1);

  // Stages 0..SYNC_STAGES-1 synchronize; the last stage is the edge reference.
  logic [SYNC_STAGES:0][NUM_SIGS-1:0] sync_q, sync_d;
  logic clk_rise, start_rise, done_rise, data_s;

  rx_state_t          state_q, state_d;
  logic [CODE_W-1:0]  shreg_q, shreg_d;
  logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_short_q, err_short_d, err_long_q, err_long_d, ovf_q, ovf_d;
  logic               push_req, push_ok, pop, set_short, set_long, set_ovf;
  logic               fifo_full, fifo_empty;

  assign sync_d = {sync_q[SYNC_STAGES-1:0], {ser_data_i, ser_done_i, ser_start_i, ser_clk_i}};
  assign clk_rise   = sync_q[SYNC_STAGES-1][SIG_CLK]   & ~sync_q[SYNC_STAGES][SIG_CLK];
  assign start_rise = sync_q[SYNC_STAGES-1][SIG_START] & ~sync_q[SYNC_STAGES][SIG_START];
  assign done_rise  = sync_q[SYNC_STAGES-1][SIG_DONE]  & ~sync_q[SYNC_STAGES][SIG_DONE];
  // Data is taken one stage behind the clock edge so it predates the rise.
  assign data_s     = sync_q[SYNC_STAGES][SIG_DATA];

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    push_req  = 1'b0;
    set_short = 1'b0;
    set_long  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_rise && enable_i) begin
          state_d   = RECV;
          shreg_d   = '0;
          bit_cnt_d = '0;
        end
      end
      RECV: begin
        if (!enable_i) begin
          state_d = IDLE;
        end else if (start_rise) begin
          shreg_d   = '0;
          bit_cnt_d = '0;
        end else begin
          if (clk_rise) begin
            shreg_d = {shreg_q[CODE_W-2:0], data_s};
            if (bit_cnt_q != BIT_SAT) bit_cnt_d = bit_cnt_q + 1'b1;
          end
          if (done_rise) state_d = CHECK;
        end
      end
      CHECK: begin
        state_d   = IDLE;
        push_req  = (bit_cnt_q == BIT_FULL);
        set_short = (bit_cnt_q <  BIT_FULL);
        set_long  = (bit_cnt_q >  BIT_FULL);
      end
      default: state_d = IDLE;
    endcase

    pop     = ~fifo_empty & code_ready_i;
    push_ok = push_req & (~fifo_full | pop);
    set_ovf = push_req & fifo_full & ~pop;
    cnt_d   = cnt_q + CNT_W'(push_ok);

    err_short_d = (err_short_q & ~clr_err_i) | set_short;
    err_long_d  = (err_long_q  & ~clr_err_i) | set_long;
    ovf_d       = (ovf_q       & ~clr_err_i) | set_ovf;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sync_q      <= '0;
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      cnt_q       <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      cnt_q       <= cnt_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      ovf_q       <= ovf_d;
    end
  end

  rlbp_code_fifo #(.DEPTH(DEPTH), .CODE_W(CODE_W)) u_fifo (
    .gclk    (wb_clk_i),
    .grst_n  (wb_rst_ni),
    .push_i  (push_ok),
    .pop_i   (pop),
    .data_i  (shreg_q),
    .data_o  (code_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level_o)
  );

  assign code_valid_o = ~fifo_empty;
  assign frame_cnt_o  = cnt_q;
  assign err_short_o  = err_short_q;
  assign err_long_o   = err_long_q;
  assign overflow_o   = ovf_q;
endmodule

// File: tb/tb_rlbp_code_receiver.sv
// Directed bench for rlbp_code_receiver: a frame table plus hand sequences
// for restart, overflow, full push+pop, set-over-clear and mid-frame reset.
module tb_rlbp_code_receiver;
  logic        clk = 1'b0;
  logic        rst_n, enable, ser_clk, ser_start, ser_data, ser_done;
  logic        code_ready, clr_err;
  logic [11:0] code;
  logic        code_valid, err_short, err_long, overflow;
  logic [2:0]  level;
  logic [15:0] frame_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rlbp_code_receiver dut (
    .wb_clk_i     (clk),
    .wb_rst_ni    (rst_n),
    .enable_i     (enable),
    .ser_clk_i    (ser_clk),
    .ser_start_i  (ser_start),
    .ser_data_i   (ser_data),
    .ser_done_i   (ser_done),
    .code_o       (code),
    .code_valid_o (code_valid),
    .code_ready_i (code_ready),
    .fifo_level_o (level),
    .frame_cnt_o  (frame_cnt),
    .err_short_o  (err_short),
    .err_long_o   (err_long),
    .overflow_o   (overflow),
    .clr_err_i    (clr_err)
  );

  typedef struct {
    logic [15:0] pat;
    int          nbits;
    logic        exp_valid;
    logic [11:0] exp_code;
    logic        exp_short;
    logic        exp_long;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[6];

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    ser_data = b;
    ser_clk  = 1'b0;
    cyc(3);
    ser_clk  = 1'b1;
    cyc(3);
    ser_clk  = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] pat, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(pat[i]);
  endtask

  task automatic send_start();
    ser_start = 1'b1;
    cyc(3);
    ser_start = 1'b0;
    cyc(3);
  endtask

  // Done edge reaches CHECK three edges after it is driven; rdy/clr are
  // raised exactly for that CHECK cycle.
  task automatic send_done(input logic rdy, input logic clr);
    ser_done = 1'b1;
    cyc(3);
    if (rdy) code_ready = 1'b1;
    if (clr) clr_err = 1'b1;
    cyc(1);
    code_ready = 1'b0;
    clr_err    = 1'b0;
    ser_done   = 1'b0;
    cyc(4);
  endtask

  task automatic frame(input logic [15:0] pat, input int n);
    send_start();
    send_bits(pat, n);
    send_done(1'b0, 1'b0);
  endtask

  task automatic pop_one();
    code_ready = 1'b1;
    cyc(1);
    code_ready = 1'b0;
    cyc(1);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    cyc(1);
    clr_err = 1'b0;
    cyc(1);
  endtask

  initial begin
    vecs[0] = '{16'h0A5C, 12, 1'b1, 12'hA5C, 1'b0, 1'b0, 16'd1};
    vecs[1] = '{16'h0A5C, 11, 1'b0, 12'h000, 1'b1, 1'b0, 16'd1};
    vecs[2] = '{16'h1A5C, 13, 1'b0, 12'h000, 1'b0, 1'b1, 16'd1};
    vecs[3] = '{16'h0123, 12, 1'b1, 12'h123, 1'b0, 1'b0, 16'd2};
    vecs[4] = '{16'h0FFF, 12, 1'b1, 12'hFFF, 1'b0, 1'b0, 16'd3};
    vecs[5] = '{16'h0000, 12, 1'b1, 12'h000, 1'b0, 1'b0, 16'd4};

    rst_n = 1'b0; enable = 1'b0; ser_clk = 1'b0; ser_start = 1'b0;
    ser_data = 1'b0; ser_done = 1'b0; code_ready = 1'b0; clr_err = 1'b0;
    cyc(3);
    chk("rst_valid", code_valid, 0);
    chk("rst_code",  code, 0);
    chk("rst_level", level, 0);
    chk("rst_cnt",   frame_cnt, 0);
    chk("rst_flags", {err_short, err_long, overflow}, 0);
    rst_n  = 1'b1;
    enable = 1'b1;
    cyc(2);

    for (int v = 0; v < 6; v++) begin
      frame(vecs[v].pat, vecs[v].nbits);
      chk($sformatf("v%0d_valid", v), code_valid, vecs[v].exp_valid);
      chk($sformatf("v%0d_code", v),  code, vecs[v].exp_code);
      chk($sformatf("v%0d_level", v), level, {2'b0, vecs[v].exp_valid});
      chk($sformatf("v%0d_short", v), err_short, vecs[v].exp_short);
      chk($sformatf("v%0d_long", v),  err_long, vecs[v].exp_long);
      chk($sformatf("v%0d_ovf", v),   overflow, 0);
      chk($sformatf("v%0d_cnt", v),   frame_cnt, vecs[v].exp_cnt);
      if (vecs[v].exp_valid) begin
        pop_one();
        chk($sformatf("v%0d_popped", v), code_valid, 0);
      end
      pulse_clr();
      chk($sformatf("v%0d_clr", v), {err_short, err_long}, 0);
    end

    // Restart after 5 bits, then a clean 0x123 frame.
    send_start();
    send_bits(16'h0016, 5);
    send_start();
    send_bits(16'h0123, 12);
    send_done(1'b0, 1'b0);
    chk("restart_code",  code, 12'h123);
    chk("restart_valid", code_valid, 1);
    chk("restart_flags", {err_short, err_long}, 0);
    chk("restart_cnt",   frame_cnt, 5);
    pop_one();

    // Overflow: five frames into a four-deep FIFO with no consumer.
    for (int k = 1; k <= 5; k++) frame(16'(k), 12);
    chk("ovf_level", level, 4);
    chk("ovf_flag",  overflow, 1);
    chk("ovf_cnt",   frame_cnt, 9);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("drain%0d", k), code, k);
      pop_one();
    end
    chk("drain_empty", code_valid, 0);
    pulse_clr();
    chk("ovf_clr", overflow, 0);

    // Full FIFO with a pop in the CHECK cycle: push still accepted.
    for (int k = 1; k <= 4; k++) frame(16'(k), 12);
    chk("fill_level", level, 4);
    send_start();
    send_bits(16'h0005, 12);
    send_done(1'b1, 1'b0);
    chk("pp_level", level, 4);
    chk("pp_ovf",   overflow, 0);
    chk("pp_cnt",   frame_cnt, 14);
    chk("pp_head",  code, 12'h002);

    // Flag set wins over a simultaneous clear.
    send_start();
    send_bits(16'h0005, 3);
    send_done(1'b0, 1'b1);
    chk("setwins_short", err_short, 1);
    pulse_clr();
    chk("setwins_clr", err_short, 0);

    // Reset in the middle of a frame with a non-empty FIFO.
    send_start();
    send_bits(16'h0A5C, 6);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", code_valid, 0);
    chk("mrst_code",  code, 0);
    chk("mrst_level", level, 0);
    chk("mrst_cnt",   frame_cnt, 0);
    chk("mrst_flags", {err_short, err_long, overflow}, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    send_bits(16'h0A5C, 6);
    send_done(1'b0, 1'b0);
    chk("post_valid", code_valid, 0);
    chk("post_level", level, 0);
    chk("post_cnt",   frame_cnt, 0);
    chk("post_flags", {err_short, err_long, overflow}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/rlbp_code_receiver.md
Name: rlbp_code_receiver

Overview:
- Receiving end of the serial code stream that rlbp_macro emits toward the pixel readout path: ser_clk (clk_o), ser_start (start_o), ser_data (data_o), ser_done (done_o).
- Oversamples the stream in the wb_clk_i domain and deserializes each frame into one CODE_W-bit LBP code.
- Validates frame length, buffers good codes in a small FIFO and presents them on a valid/ready interface, so firmware or the LA can drain them.

Parameters:
- CODE_W, 12, bits per code; one bit per photodiode pair, MSB first.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the good-frame counter.

Ports:
- wb_clk_i  in  1  system clock; all logic is synchronous to it.
- wb_rst_ni  in  1  asynchronous active-low reset.
- enable_i  in  1  receiver enable; when 0, start edges are ignored.
- ser_clk_i  in  1  serial bit clock, asynchronous, at most wb_clk_i/4.
- ser_start_i  in  1  frame start level/pulse, asynchronous.
- ser_data_i  in  1  serial data, valid at the rising edge of ser_clk_i.
- ser_done_i  in  1  frame end, asynchronous.
- code_o  out  CODE_W  FIFO head.
- code_valid_o  out  1  FIFO not empty.
- code_ready_i  in  1  consumer accepts the head when valid & ready.
- fifo_level_o  out  $clog2(DEPTH)+1  entries held.
- frame_cnt_o  out  CNT_W  good frames pushed; wraps.
- err_short_o  out  1  sticky: done arrived with fewer than CODE_W bits.
- err_long_o  out  1  sticky: more than CODE_W bits arrived.
- overflow_o  out  1  sticky: good frame dropped because the FIFO was full.
- clr_err_i  in  1  one-cycle pulse; clears all sticky flags.

Behaviour:
- Reset, asynchronous: state IDLE, FIFO empty, code_o=0, code_valid_o=0, fifo_level_o=0, frame_cnt_o=0, all sticky flags 0, synchronizers 0.
- Input capture:
  - ser_clk_i, ser_start_i, ser_done_i and ser_data_i each pass through a 2-FF synchronizer, then one more register for rising-edge detection.
  - Because all four share identical stage counts, their relative order is preserved.
  - Bit shift occurs 3 wb_clk_i cycles after a ser_clk_i rising edge.
- FSM IDLE:
  - start_rise & enable_i -> RECV.
  - Entering RECV clears the shift register and sets bit_cnt=0.
- FSM RECV:
  - Each ser_clk rise: shreg={shreg[CODE_W-2:0],data_s}; bit_cnt saturates at CODE_W+1.
  - start_rise -> restart: shreg and bit_cnt cleared, stay in RECV, no error flag.
  - done_rise -> CHECK.
  - If ser_clk rise and done_rise fall in the same cycle, the bit is shifted first, then CHECK.
  - enable_i=0 -> IDLE; partial frame discarded, no flag.
- FSM CHECK, one cycle, then IDLE:
  - bit_cnt==CODE_W: push shreg and increment frame_cnt_o. If the FIFO is full, drop the word, set overflow_o, and leave frame_cnt_o unchanged.
  - bit_cnt<CODE_W: set err_short_o, no push.
  - bit_cnt>CODE_W: set err_long_o, no push.
- FIFO:
  - Write happens on the CHECK cycle edge; code_valid_o is high the following cycle.
  - Pop on code_valid_o & code_ready_i; code_o shows the next entry the following cycle.
  - Push and pop in the same cycle when full: both succeed, level unchanged, no overflow.
  - Pop when empty is ignored.
  - Pointers are $clog2(DEPTH)+1 bits and wrap naturally.
- clr_err_i in the same cycle as a flag-set event: the set wins.
- frame_cnt_o wraps from 2^CNT_W-1 to 0.
- Reset asserted mid-frame or mid-pop returns everything to reset values immediately; nothing is pushed.

Decomposition:
- Package rlbp_pkg holds:
  - CODE_W_DEF=12.
  - State enum rx_state_t {IDLE,RECV,CHECK}.
  - SYNC_STAGES=2.
- One sub-module, rlbp_code_fifo: synchronous FIFO (DEPTH, CODE_W) with push/pop/full/empty/level.
- Synchronizers and the FSM stay in the top module.

Test Plan:
- Good frame: enable_i=1, start, 12 bits of 0xA5C MSB first, done -> code_o=0xA5C, code_valid_o=1, frame_cnt_o=1, no flags.
- Short frame: 11 bits then done -> err_short_o=1, fifo_level_o=0; clr_err_i pulse clears it to 0.
- Long frame and restart: 13 bits then done -> err_long_o=1, no push. Then start after 5 bits, followed by 12 bits of 0x123 and done -> code_o=0x123, no error.
- Overflow: code_ready_i=0, send 5 good frames 0x001..0x005 -> fifo_level_o=4, overflow_o=1, frame_cnt_o=4. Draining returns 0x001..0x004 in order.
- Full push+pop: FIFO full, code_ready_i=1 held while the 5th frame is in CHECK -> level stays 4, overflow_o=0, frame_cnt_o increments.
- Reset mid-frame: deassert wb_rst_ni after 6 bits -> all outputs 0. Completing the remaining bits plus done pushes nothing, and no flags are set.
